// File: rtl/gpu_pipe_pkg.sv
// Shared GPU pipeline types and constants: colour width, layer index width and the
// pixel-resolve priority used by the layer compositor.
package gpu_pipe_pkg;

  localparam int RGB_W = 24;
  localparam int LAYER_W = 5;
  localparam logic [LAYER_W-1:0] TRANSPARENT_IDX = 5'd0;

  typedef logic [RGB_W-1:0] rgb888_t;

  localparam rgb888_t BG_DEFAULT = 24'h000000;

  // Front-most hit wins, then the current beat's own colour, then the background.
  function automatic rgb888_t resolvePixel(input logic effHit, input rgb888_t held,
                                           input logic found, input rgb888_t rgb,
                                           input rgb888_t bg);
    rgb888_t result;
    if (effHit) begin
      result = held;
    end else if (found) begin
      result = rgb;
    end else begin
      result = bg;
    end
    return result;
  endfunction

endpackage

// File: rtl/pixel_fifo.sv
// Show-ahead FIFO with count-based full/empty; the register array has no reset,
// only the pointers and the count do.
module pixel_fifo
  import gpu_pipe_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4,
  parameter int DATA_W = RGB_W
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              push_i,
  input  logic [DATA_W-1:0] pushData_i,
  input  logic              pop_i,
  output logic              full_o,
  output logic              empty_o,
  output logic [DATA_W-1:0] headData_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [ADDR_W-1:0] wrPtr_q, wrPtr_d, rdPtr_q, rdPtr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              doPush, doPop;

  assign full_o     = (count_q == (ADDR_W+1)'(DEPTH));
  assign empty_o    = (count_q == '0);
  assign doPush     = push_i & !full_o;
  assign doPop      = pop_i & !empty_o;
  assign headData_o = empty_o ? '0 : mem_q[rdPtr_q];

  // Pointers are exactly ADDR_W bits wide, so they wrap modulo DEPTH on their own.
  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    count_d = count_q;
    if (doPush) wrPtr_d = wrPtr_q + ADDR_W'(1);
    if (doPop)  rdPtr_d = rdPtr_q + ADDR_W'(1);
    case ({doPush, doPop})
      2'b10:   count_d = count_q + (ADDR_W+1)'(1);
      2'b01:   count_d = count_q - (ADDR_W+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (doPush) mem_q[wrPtr_q] <= pushData_i;
  end

endmodule

// File: rtl/layer_compositor.sv
// Resolves per-layer beats into one pixel (first opaque layer or background) and queues it
// for the HDMI side. Optional underflow monitor: define LAYER_COMPOSITOR_UNDERFLOW_EN.
module layer_compositor
  import gpu_pipe_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int ADDR_W     = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        inValid_i,
  output logic        inReady_o,
  input  logic        inFirst_i,
  input  logic        inLast_i,
  input  logic        inPixelFound_i,
  input  logic [23:0] inRGB_i,
  input  logic [23:0] bgColor_i,
  output logic        outValid_o,
  input  logic        outReady_i,
  output logic [23:0] outRGB_o,
  output logic        protoErr_o
`ifdef LAYER_COMPOSITOR_UNDERFLOW_EN
  ,
  output logic        underflowFlag_o,
  output logic [15:0] underflowCount_o
`endif
);

  logic    hit_q, hit_d, inPixel_q, inPixel_d, protoErr_q, protoErr_d;
  rgb888_t held_q, held_d, pushData;
  logic    accept, effHit, takeNew, push, fifoFull, fifoEmpty;

  assign inReady_o  = !fifoFull;
  assign accept     = inValid_i & inReady_o;
  assign effHit     = inFirst_i ? 1'b0 : hit_q;
  assign takeNew    = !effHit & inPixelFound_i;
  assign push       = accept & inLast_i;
  assign pushData   = resolvePixel(effHit, held_q, inPixelFound_i, inRGB_i, bgColor_i);
  assign outValid_o = !fifoEmpty;
  assign protoErr_o = protoErr_q;

  // An inFirst beat discards whatever the previous pixel had accumulated.
  always_comb begin
    hit_d      = hit_q;
    held_d     = held_q;
    inPixel_d  = inPixel_q;
    protoErr_d = protoErr_q;
    if (accept) begin
      if (takeNew) begin
        held_d = inRGB_i;
        hit_d  = 1'b1;
      end else if (inFirst_i) begin
        hit_d = 1'b0;
      end
      if (inLast_i) hit_d = 1'b0;
      inPixel_d = !inLast_i;
      if (inFirst_i & inPixel_q) protoErr_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hit_q      <= 1'b0;
      held_q     <= '0;
      inPixel_q  <= 1'b0;
      protoErr_q <= 1'b0;
    end else begin
      hit_q      <= hit_d;
      held_q     <= held_d;
      inPixel_q  <= inPixel_d;
      protoErr_q <= protoErr_d;
    end
  end

  pixel_fifo #(
    .DEPTH (FIFO_DEPTH),
    .ADDR_W(ADDR_W),
    .DATA_W(RGB_W)
  ) u_fifo (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .push_i    (push),
    .pushData_i(pushData),
    .pop_i     (outReady_i),
    .full_o    (fifoFull),
    .empty_o   (fifoEmpty),
    .headData_o(outRGB_o)
  );

`ifdef LAYER_COMPOSITOR_UNDERFLOW_EN
  logic        underflowFlag_q, underflowFlag_d;
  logic [15:0] underflowCount_q, underflowCount_d;

  // Counts cycles the HDMI side asked for a pixel that was not there; saturates.
  always_comb begin
    underflowFlag_d  = underflowFlag_q;
    underflowCount_d = underflowCount_q;
    if (outReady_i & fifoEmpty) begin
      underflowFlag_d = 1'b1;
      if (underflowCount_q != 16'hFFFF) underflowCount_d = underflowCount_q + 16'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      underflowFlag_q  <= 1'b0;
      underflowCount_q <= '0;
    end else begin
      underflowFlag_q  <= underflowFlag_d;
      underflowCount_q <= underflowCount_d;
    end
  end

  assign underflowFlag_o  = underflowFlag_q;
  assign underflowCount_o = underflowCount_q;
`endif

endmodule

// File: tb/tb_layer_compositor.sv
// Directed bench for layer_compositor with a queue scoreboard of resolved pixels.
module tb_layer_compositor;
  import gpu_pipe_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        inValid, inReady, inFirst, inLast, inPixelFound;
  logic [23:0] inRGB, bgColor, outRGB;
  logic        outValid, outReady, protoErr;
`ifdef LAYER_COMPOSITOR_UNDERFLOW_EN
  logic        underflowFlag;
  logic [15:0] underflowCount;
`endif

  int      testsRun = 0;
  int      testsFailed = 0;
  int      validCycles = 0;
  rgb888_t expQ[$];

  always #5 clk = ~clk;

  layer_compositor #(.FIFO_DEPTH(16), .ADDR_W(4)) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .inValid_i     (inValid),
    .inReady_o     (inReady),
    .inFirst_i     (inFirst),
    .inLast_i      (inLast),
    .inPixelFound_i(inPixelFound),
    .inRGB_i       (inRGB),
    .bgColor_i     (bgColor),
    .outValid_o    (outValid),
    .outReady_i    (outReady),
    .outRGB_o      (outRGB),
    .protoErr_o    (protoErr)
`ifdef LAYER_COMPOSITOR_UNDERFLOW_EN
    ,
    .underflowFlag_o (underflowFlag),
    .underflowCount_o(underflowCount)
`endif
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testsRun++;
    assert (observed === expected) else begin
      testsFailed++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Drive one beat and hold it until accepted; inputs change #1 after posedge.
  task automatic applyStimulus(input logic first, input logic last, input logic found,
                               input rgb888_t rgb, input rgb888_t bg);
    int budget = 0;
    inValid = 1'b1; inFirst = first; inLast = last;
    inPixelFound = found; inRGB = rgb; bgColor = bg;
    while (!inReady && budget < 100) begin
      @(posedge clk); #1;
      budget++;
    end
    checkOutput("acceptTimeout", 32'(budget < 100), 32'd1);
    @(posedge clk); #1;
    inValid = 1'b0; inFirst = 1'b0; inLast = 1'b0; inPixelFound = 1'b0;
  endtask

  task automatic waitDrain();
    int budget = 0;
    while ((expQ.size() != 0 || outValid) && budget < 200) begin
      @(posedge clk); #1;
      budget++;
    end
    checkOutput("drainTimeout", 32'(budget < 200), 32'd1);
  endtask

  // Scoreboard: a pop happens on the next posedge whenever valid & ready hold at negedge.
  always @(negedge clk) begin
    if (outValid) validCycles++;
    if (rst_n && outValid && outReady) begin
      checkOutput("popHasExpected", 32'(expQ.size() > 0), 32'd1);
      if (expQ.size() > 0) checkOutput("popData", 32'(outRGB), 32'(expQ.pop_front()));
    end
  end

  initial begin
    rst_n = 1'b0; inValid = 1'b0; inFirst = 1'b0; inLast = 1'b0; inPixelFound = 1'b0;
    inRGB = '0; bgColor = BG_DEFAULT; outReady = 1'b0;
    #12;
    checkOutput("rstInReady", 32'(inReady), 32'd1);
    checkOutput("rstOutValid", 32'(outValid), 32'd0);
    checkOutput("rstOutRGB", 32'(outRGB), 32'd0);
    checkOutput("rstProtoErr", 32'(protoErr), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Test 1: front-most opaque layer wins; one-cycle latency into the empty FIFO.
    outReady = 1'b1;
    validCycles = 0;
    applyStimulus(1'b1, 1'b0, 1'b0, 24'h010101, BG_DEFAULT);
    applyStimulus(1'b0, 1'b0, 1'b1, 24'h112233, BG_DEFAULT);
    applyStimulus(1'b0, 1'b0, 1'b1, 24'h445566, BG_DEFAULT);
    expQ.push_back(24'h112233);
    applyStimulus(1'b0, 1'b1, 1'b0, 24'h778899, BG_DEFAULT);
    checkOutput("t1Latency", 32'(outValid), 32'd1);
    checkOutput("t1Head", 32'(outRGB), 32'h112233);
    repeat (4) @(posedge clk);
    #1;
    checkOutput("t1ValidCycles", 32'(validCycles), 32'd1);

    // Test 2: all-transparent pixel takes background; single-beat pixel.
    applyStimulus(1'b1, 1'b0, 1'b0, 24'h111111, BG_DEFAULT);
    applyStimulus(1'b0, 1'b0, 1'b0, 24'h222222, BG_DEFAULT);
    expQ.push_back(24'h0000FF);
    applyStimulus(1'b0, 1'b1, 1'b0, 24'h333333, 24'h0000FF);
    expQ.push_back(24'hABCDEF);
    applyStimulus(1'b1, 1'b1, 1'b1, 24'hABCDEF, 24'h0000FF);
    waitDrain();

    // Test 3: fill to full, hold off a 17th beat, drain across the pointer wrap.
    outReady = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      expQ.push_back(24'(i));
      applyStimulus(1'b1, 1'b1, 1'b1, 24'(i), BG_DEFAULT);
    end
    checkOutput("t3FullInReady", 32'(inReady), 32'd0);
    checkOutput("t3FullHead", 32'(outRGB), 32'd1);
    inValid = 1'b1; inFirst = 1'b1; inLast = 1'b1; inPixelFound = 1'b1; inRGB = 24'd17;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("t3HeldOff", 32'(inReady), 32'd0);
    inValid = 1'b0;
    outReady = 1'b1;
    @(posedge clk); #1;
    checkOutput("t3ReadyAfterPop", 32'(inReady), 32'd1);
    waitDrain();
    checkOutput("t3DrainedReady", 32'(inReady), 32'd1);

    // Test 4: five queued, then simultaneous push/pop every cycle keeps the level at five.
    outReady = 1'b0;
    for (int i = 0; i < 5; i++) begin
      expQ.push_back(24'h000200 + 24'(i));
      applyStimulus(1'b1, 1'b1, 1'b1, 24'h000200 + 24'(i), BG_DEFAULT);
    end
    outReady = 1'b1;
    for (int i = 0; i < 40; i++) begin
      expQ.push_back(24'h000300 + 24'(i));
      applyStimulus(1'b1, 1'b1, 1'b1, 24'h000300 + 24'(i), BG_DEFAULT);
      checkOutput("t4Valid", 32'(outValid), 32'd1);
      checkOutput("t4NotFull", 32'(inReady), 32'd1);
    end
    checkOutput("t4Level", 32'(expQ.size()), 32'd5);
    waitDrain();

    // Test 5: restart mid-pixel flags the error and drops the old pixel's hit.
    applyStimulus(1'b1, 1'b0, 1'b1, 24'hDEAD01, BG_DEFAULT);
    checkOutput("t5NoErrYet", 32'(protoErr), 32'd0);
    applyStimulus(1'b1, 1'b0, 1'b0, 24'h111111, BG_DEFAULT);
    checkOutput("t5ErrSet", 32'(protoErr), 32'd1);
    expQ.push_back(24'h5A5A5A);
    applyStimulus(1'b0, 1'b1, 1'b1, 24'h5A5A5A, BG_DEFAULT);
    expQ.push_back(24'h123456);
    applyStimulus(1'b1, 1'b1, 1'b0, 24'h999999, 24'h123456);
    waitDrain();
    checkOutput("t5ErrSticky", 32'(protoErr), 32'd1);

    // Test 6: reset with three queued and a pixel in flight discards everything at once.
    outReady = 1'b0;
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1, 1'b1, 24'h0A0A00 + 24'(i), BG_DEFAULT);
    applyStimulus(1'b1, 1'b0, 1'b1, 24'h777777, BG_DEFAULT);
    checkOutput("t6PreResetValid", 32'(outValid), 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("t6RstValid", 32'(outValid), 32'd0);
    checkOutput("t6RstReady", 32'(inReady), 32'd1);
    checkOutput("t6RstRGB", 32'(outRGB), 32'd0);
    checkOutput("t6RstProtoErr", 32'(protoErr), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
`ifdef LAYER_COMPOSITOR_UNDERFLOW_EN
    checkOutput("t6UfCountReset", 32'(underflowCount), 32'd0);
    checkOutput("t6UfFlagReset", 32'(underflowFlag), 32'd0);
    outReady = 1'b1;
    repeat (7) @(posedge clk);
    #1;
    outReady = 1'b0;
    @(posedge clk); #1;
    checkOutput("t6UfCount", 32'(underflowCount), 32'd7);
    checkOutput("t6UfFlag", 32'(underflowFlag), 32'd1);
`endif
    outReady = 1'b1;
    expQ.push_back(24'h0F0F0F);
    applyStimulus(1'b1, 1'b1, 1'b1, 24'h0F0F0F, BG_DEFAULT);
    waitDrain();

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
